// File: rtl/keypad_digit_entry.sv
// 4x4 keypad scanner with debounce, key decode and two 4-digit BCD operand entry.
// Optional backspace on key 13 is enabled by defining KEYPAD_BACKSPACE_EN.
module keypad_digit_entry #(
    parameter int unsigned DIV      = 100,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [3:0] A4,
    output logic [3:0] B1,
    output logic [3:0] B2,
    output logic [3:0] B3,
    output logic [3:0] B4,
    output logic [1:0] ST,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int unsigned TW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED} scan_t;
    typedef enum logic [1:0] {ENTER_A = 2'd0, ENTER_B = 2'd1, DONE = 2'd2} entry_t;

    scan_t         scan_st;
    entry_t        entry_st;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] db_cnt;
    logic [3:0]    latched;
    logic          tick;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [3:0]    cur_code;

    assign tick     = (tick_cnt == TICK_LAST);
    assign cur_code = {row_idx, col_idx};
    assign ST       = entry_st;

    // Lowest pressed row wins; column index comes from the one-hot drive.
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (row[i]) row_idx = 2'(i);
        end
        col_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (col[i]) col_idx = 2'(i);
        end
    end

    // Scan tick divider and scan/debounce FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            scan_st   <= S_SCAN;
            db_cnt    <= '0;
            latched   <= 4'd0;
            col       <= 4'b0001;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_valid <= 1'b0;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                case (scan_st)
                    S_SCAN: begin
                        if (row == 4'd0) begin
                            col <= {col[2:0], col[3]};
                        end else begin
                            latched <= cur_code;
                            db_cnt  <= '0;
                            scan_st <= S_DEBOUNCE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (row != 4'd0 && cur_code == latched) begin
                            if (db_cnt == DB_LAST) begin
                                scan_st   <= S_PRESSED;
                                key_valid <= 1'b1;
                                key_code  <= latched;
                                db_cnt    <= '0;
                            end else begin
                                db_cnt <= db_cnt + DW'(1);
                            end
                        end else begin
                            scan_st <= S_SCAN;
                        end
                    end
                    S_PRESSED: begin
                        // Release must also be stable before scanning resumes.
                        if (row == 4'd0) begin
                            if (db_cnt == DB_LAST) begin
                                scan_st <= S_SCAN;
                                db_cnt  <= '0;
                            end else begin
                                db_cnt <= db_cnt + DW'(1);
                            end
                        end else begin
                            db_cnt <= '0;
                        end
                    end
                    default: scan_st <= S_SCAN;
                endcase
            end
        end
    end

    // Operand entry, acting on each accepted key.
    always_ff @(posedge clk) begin
        if (rst) begin
            {A4, A3, A2, A1} <= 16'd0;
            {B4, B3, B2, B1} <= 16'd0;
            entry_st         <= ENTER_A;
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (entry_st == ENTER_A) begin
                    {A4, A3, A2, A1} <= {A3, A2, A1, key_code};
                end else if (entry_st == ENTER_B) begin
                    {B4, B3, B2, B1} <= {B3, B2, B1, key_code};
                end
            end else begin
                case (key_code)
                    4'd10: if (entry_st == ENTER_A) entry_st <= ENTER_B;
                    4'd11: if (entry_st == ENTER_B) entry_st <= DONE;
                    4'd12: begin
                        {A4, A3, A2, A1} <= 16'd0;
                        {B4, B3, B2, B1} <= 16'd0;
                        entry_st         <= ENTER_A;
                    end
`ifdef KEYPAD_BACKSPACE_EN
                    4'd13: begin
                        if (entry_st == ENTER_A) begin
                            {A4, A3, A2, A1} <= {4'd0, A4, A3, A2};
                        end else if (entry_st == ENTER_B) begin
                            {B4, B3, B2, B1} <= {4'd0, B4, B3, B2};
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry (DIV=4, DEBOUNCE=2) with a keypad matrix model.
module tb_keypad_digit_entry;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] A1, A2, A3, A4, B1, B2, B3, B4;
    logic [1:0] ST;
    logic       key_valid;
    logic [3:0] key_code;

    logic [15:0] keys;
    int n_checks;
    int n_fail;
    int ma, mb, mst;

    keypad_digit_entry #(.DIV(4), .DEBOUNCE(2)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .ST(ST), .key_valid(key_valid), .key_code(key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: key 4r+c connects column c to row r.
    always_comb begin
        row = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && col[c]) row[r] = 1'b1;
            end
        end
    end

    typedef struct {
        int code;
        int exp_a;
        int exp_b;
        int exp_st;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Operands modelled as decimal integers.
    task automatic model_key(input int code);
        if (code <= 9) begin
            if (mst == 0) ma = (ma * 10 + code) % 10000;
            else if (mst == 1) mb = (mb * 10 + code) % 10000;
        end else if (code == 10) begin
            if (mst == 0) mst = 1;
        end else if (code == 11) begin
            if (mst == 1) mst = 2;
        end else if (code == 12) begin
            ma = 0; mb = 0; mst = 0;
        end
`ifdef KEYPAD_BACKSPACE_EN
        else if (code == 13) begin
            if (mst == 0) ma = ma / 10;
            else if (mst == 1) mb = mb / 10;
        end
`endif
    endtask

    task automatic check_model(input string tag);
        check({tag, "_A"}, int'({A4, A3, A2, A1}), to_bcd(ma));
        check({tag, "_B"}, int'({B4, B3, B2, B1}), to_bcd(mb));
        check({tag, "_ST"}, int'(ST), mst);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keys = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ma = 0; mb = 0; mst = 0;
    endtask

    task automatic press_key(input int code, input int hold);
        int pulses;
        int got;
        pulses = 0;
        got = -1;
        keys = 16'd0;
        keys[code] = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin pulses++; got = int'(key_code); end
        end
        keys = 16'd0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin pulses++; got = int'(key_code); end
        end
        check("pulse_count", pulses, 1);
        check("pulse_code", got, code);
        check("key_code_held", int'(key_code), code);
        model_key(code);
        check_model("entry");
    endtask

    vec_t vecs[15];
    int   bad;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        keys     = 16'd0;

        // Idle scanning after reset.
        do_reset();
        check("rst_col", int'(col), 1);
        check("rst_kv", int'(key_valid), 0);
        check("rst_code", int'(key_code), 0);
        check_model("rst");
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (key_valid) bad++;
            if (k % 4 == 0) check("idle_col", int'(col), 1 << ((k / 4) % 4));
        end
        check("idle_no_kv", bad, 0);

        // Glitch, then a two-row press in column 0.
        do_reset();
        keys[8] = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            check("bounce_kv", int'(key_valid), (k == 20) ? 1 : 0);
            if (k == 5) keys = 16'd0;
            if (k == 9) begin keys[8] = 1'b1; keys[12] = 1'b1; end
            if (k == 24) keys = 16'd0;
        end
        check("multirow_code", int'(key_code), 8);
        repeat (30) @(posedge clk);
        #1;
        model_key(8);
        check_model("bounce");

        // Reset while debouncing.
        do_reset();
        keys[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        keys = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        ma = 0; mb = 0; mst = 0;
        check("rstdb_col", int'(col), 1);
        check("rstdb_kv", int'(key_valid), 0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (key_valid) bad++;
        end
        check("rstdb_no_event", bad, 0);
        check_model("rstdb");

        // Directed key table.
        vecs[0]  = '{5,  'h0005, 'h0000, 0};
        vecs[1]  = '{12, 'h0000, 'h0000, 0};
        vecs[2]  = '{1,  'h0001, 'h0000, 0};
        vecs[3]  = '{2,  'h0012, 'h0000, 0};
        vecs[4]  = '{3,  'h0123, 'h0000, 0};
        vecs[5]  = '{4,  'h1234, 'h0000, 0};
        vecs[6]  = '{5,  'h2345, 'h0000, 0};
        vecs[7]  = '{12, 'h0000, 'h0000, 0};
        vecs[8]  = '{7,  'h0007, 'h0000, 0};
        vecs[9]  = '{15, 'h0007, 'h0000, 0};
        vecs[10] = '{10, 'h0007, 'h0000, 1};
        vecs[11] = '{9,  'h0007, 'h0009, 1};
        vecs[12] = '{11, 'h0007, 'h0009, 2};
        vecs[13] = '{3,  'h0007, 'h0009, 2};
        vecs[14] = '{12, 'h0000, 'h0000, 0};
        do_reset();
        foreach (vecs[i]) begin
            press_key(vecs[i].code, 80);
            check("tbl_A", int'({A4, A3, A2, A1}), vecs[i].exp_a);
            check("tbl_B", int'({B4, B3, B2, B1}), vecs[i].exp_b);
            check("tbl_ST", int'(ST), vecs[i].exp_st);
        end

        // Backspace key on a partial operand and on an empty one.
        do_reset();
        press_key(1, 60);
        press_key(2, 60);
        press_key(3, 60);
        press_key(13, 60);
`ifdef KEYPAD_BACKSPACE_EN
        check("bs_A", int'({A4, A3, A2, A1}), 'h0012);
`else
        check("bs_A", int'({A4, A3, A2, A1}), 'h0123);
`endif
        press_key(12, 60);
        press_key(13, 60);
        check("bs_empty_A", int'({A4, A3, A2, A1}), 0);

        // Random key sequences against the decimal model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            press_key(int'($urandom_range(15, 0)), int'($urandom_range(100, 40)));
            check("rnd_st_range", int'(ST != 2'd3), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
Upstream stage of the LCD datapath. Scans a 4x4 matrix keypad, debounces presses and decodes each key to a 4-bit code. It assembles two 4-digit BCD operands (A1..A4, B1..B4) and an entry-state code ST, which the LCD datapath renders. Runs on the fast system clock and derives its own scan tick internally.

Parameters:
DIV, 100, system clocks per scan tick (minimum 2).
DEBOUNCE, 4, consecutive scan ticks a level must stay stable to be accepted (minimum 1).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
row  in  4  keypad rows; bit r = 1 when a key in row r of the driven column is pressed
col  out  4  one-hot column drive
A1..A4  out  4 each  operand A BCD digits; A1 least significant
B1..B4  out  4 each  operand B BCD digits; B1 least significant
ST  out  2  entry state: 0 ENTER_A, 1 ENTER_B, 2 DONE (3 unused)
key_valid  out  1  one-clk pulse per accepted key
key_code  out  4  code of the last accepted key; held between pulses

Behaviour:
- Reset values: col=4'b0001; A1..A4=B1..B4=0; ST=0; key_valid=0; key_code=0; tick counter=0; scan FSM in SCAN; debounce counter=0.
- Tick: counter counts 0..DIV-1 and wraps. tick=1 for one clk when the counter is DIV-1. All scan FSM activity happens only on tick cycles.
- Key code = 4*r + c. r = lowest-index set row bit (multiple rows: lowest wins). c = index of the active col bit.
- Scan FSM:
  - SCAN: on tick, if row==0, rotate col left (0001->0010->0100->1000->0001). Otherwise latch the code, clear the debounce counter and go to DEBOUNCE; col holds.
  - DEBOUNCE: on tick, if the current code equals the latched code with row!=0, increment the counter; reaching DEBOUNCE -> PRESSED. If the code differs or row==0 -> SCAN, with no event and no col rotation that tick.
  - PRESSED: on entry, key_valid=1 for exactly one clk, coinciding with the entry edge, and key_code is updated. The state then waits on ticks until row==0 for DEBOUNCE consecutive ticks; any nonzero row restarts that count. Then -> SCAN; col rotates on the next tick.
  - Holding a key yields exactly one event.
- Entry FSM: acts only in the clk where key_valid=1; registers update on that same edge.
  - Digits 0..9 in ENTER_A: A4<=A3, A3<=A2, A2<=A1, A1<=code. ENTER_B: same shift on B. DONE: ignored. A 5th digit discards the oldest.
  - Code 10: ENTER_A -> ENTER_B; ignored elsewhere.
  - Code 11: ENTER_B -> DONE; ignored elsewhere.
  - Code 12: from any state, clear all digits and set ST=ENTER_A.
  - Codes 13..15: ignored (see optional feature).
- rst asserted mid-scan or mid-debounce: all state returns to reset values on that edge. No pending event survives.
- Digits are always in 0..9. ST never takes value 3.

Optional Feature:
KEYPAD_BACKSPACE_EN
- Defined: code 13 in ENTER_A or ENTER_B deletes the newest digit of the active operand (A1<=A2, A2<=A3, A3<=A4, A4<=0; same for B). In DONE it is ignored. On an all-zero operand it is a no-op.
- Undefined: code 13 is ignored like 14 and 15.

Test Plan:
(all with DIV=4, DEBOUNCE=2)
- Reset release, no keys -> col cycles 0001,0010,0100,1000,0001, one step every 4 clks; key_valid stays 0; all outputs 0.
- Press r=1 when col=0010 (code 5), hold 20 ticks, release -> exactly one key_valid pulse, key_code=5, A1=5, ST=0.
- Enter 1,2,3,4,5 as digits -> A4..A1=2,3,4,5; ST=0.
- Sequence 7, code10, 9, code11, 3 -> A1=7, B1=9, ST=2; the final 3 is ignored (B1 stays 9). Then code 12 -> all digits 0, ST=0.
- Bounce: row nonzero for 1 tick, then 0, then nonzero again -> no event for the glitch; event only after 2 stable ticks. Two rows pressed in col 0001 (rows 2 and 3) -> key_code=8.
- Assert rst in DEBOUNCE -> next cycle col=0001, no key_valid. With KEYPAD_BACKSPACE_EN: A=1,2,3 then code 13 -> A2..A1=1,2, A3=0.
